// File: rtl/rob_retire_stage.sv
// Reorder buffer bookkeeping: allocation at the tail, completion marks and in-order retire
// of up to WIDTH consecutive done entries from the head, presented as registered lanes.
module rob_retire_stage #(
  parameter int ROB_DEPTH      = 32,
  parameter int ROB_ADDR_WIDTH = 5,
  parameter int WIDTH          = 3,
  parameter int PR_ADDR_WIDTH  = 6,
  parameter int XLEN           = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       squash,
  input  logic [WIDTH-1:0]                           disp_valid,
  input  logic [WIDTH-1:0][4:0]                      disp_arch_reg,
  input  logic [WIDTH-1:0][PR_ADDR_WIDTH-1:0]        disp_new_pr,
  input  logic [WIDTH-1:0][PR_ADDR_WIDTH-1:0]        disp_old_pr,
  input  logic [WIDTH-1:0][XLEN-1:0]                 disp_pc,
  input  logic [WIDTH-1:0]                           cs_retire_valid,
  input  logic [WIDTH-1:0][ROB_ADDR_WIDTH-1:0]       cs_retire_idx,
  output logic [ROB_ADDR_WIDTH-1:0]                  rob_tail_idx,
  output logic [ROB_ADDR_WIDTH:0]                    rob_free_slots,
  output logic                                       disp_reject,
  output logic [WIDTH-1:0]                           rt_valid,
  output logic [WIDTH-1:0][4:0]                      rt_arch_reg,
  output logic [WIDTH-1:0][PR_ADDR_WIDTH-1:0]        rt_new_pr,
  output logic [WIDTH-1:0][PR_ADDR_WIDTH-1:0]        rt_old_pr,
  output logic [WIDTH-1:0][XLEN-1:0]                 rt_pc,
  output logic [1:0]                                 rt_count
);

  localparam int CW = ROB_ADDR_WIDTH + 1;
  typedef logic [ROB_ADDR_WIDTH-1:0] idx_t;
  typedef logic [CW-1:0]             cnt_t;

  logic [ROB_DEPTH-1:0]     ent_valid;
  logic [ROB_DEPTH-1:0]     ent_done;
  logic [4:0]               ent_arch [ROB_DEPTH];
  logic [PR_ADDR_WIDTH-1:0] ent_new_pr [ROB_DEPTH];
  logic [PR_ADDR_WIDTH-1:0] ent_old_pr [ROB_DEPTH];
  logic [XLEN-1:0]          ent_pc [ROB_DEPTH];

  idx_t head;
  idx_t tail;
  cnt_t occ;

  cnt_t             disp_n;
  logic             disp_ok;
  idx_t             disp_slot [WIDTH];
  cnt_t             ret_n;
  logic [WIDTH-1:0] ret_lane;
  idx_t             ret_slot [WIDTH];

  assign rob_tail_idx   = tail;
  assign rob_free_slots = cnt_t'(ROB_DEPTH) - occ;

  // Each valid lane takes the next slot after the lanes below it.
  always_comb begin
    disp_n = '0;
    for (int k = 0; k < WIDTH; k++) begin
      disp_slot[k] = tail + idx_t'(disp_n);
      if (disp_valid[k]) disp_n = disp_n + cnt_t'(1);
    end
    disp_ok = (disp_n <= rob_free_slots);
  end

  // Retire run stops at the first entry from head that is not valid and done.
  always_comb begin
    ret_n    = '0;
    ret_lane = '0;
    for (int k = 0; k < WIDTH; k++) begin
      ret_slot[k] = head + idx_t'(k);
      if (ret_n == cnt_t'(k) && ent_valid[ret_slot[k]] && ent_done[ret_slot[k]]) begin
        ret_lane[k] = 1'b1;
        ret_n       = ret_n + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!squash && disp_ok) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (disp_valid[k]) begin
          ent_arch[disp_slot[k]]   <= disp_arch_reg[k];
          ent_new_pr[disp_slot[k]] <= disp_new_pr[k];
          ent_old_pr[disp_slot[k]] <= disp_old_pr[k];
          ent_pc[disp_slot[k]]     <= disp_pc[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid   <= '0;
      ent_done    <= '0;
      head        <= '0;
      tail        <= '0;
      occ         <= '0;
      disp_reject <= 1'b0;
      rt_valid    <= '0;
      rt_count    <= '0;
      rt_arch_reg <= '0;
      rt_new_pr   <= '0;
      rt_old_pr   <= '0;
      rt_pc       <= '0;
    end else if (squash) begin
      ent_valid   <= '0;
      ent_done    <= '0;
      head        <= '0;
      tail        <= '0;
      occ         <= '0;
      disp_reject <= 1'b0;
      rt_valid    <= '0;
      rt_count    <= '0;
      rt_arch_reg <= '0;
      rt_new_pr   <= '0;
      rt_old_pr   <= '0;
      rt_pc       <= '0;
    end else begin
      disp_reject <= !disp_ok;

      for (int k = 0; k < WIDTH; k++) begin
        if (cs_retire_valid[k] && ent_valid[cs_retire_idx[k]])
          ent_done[cs_retire_idx[k]] <= 1'b1;
      end

      // Retiring entries are already done, so clearing after the completion loop is safe.
      for (int k = 0; k < WIDTH; k++) begin
        if (ret_lane[k]) begin
          ent_valid[ret_slot[k]] <= 1'b0;
          ent_done[ret_slot[k]]  <= 1'b0;
        end
        rt_arch_reg[k] <= ret_lane[k] ? ent_arch[ret_slot[k]]   : '0;
        rt_new_pr[k]   <= ret_lane[k] ? ent_new_pr[ret_slot[k]] : '0;
        rt_old_pr[k]   <= ret_lane[k] ? ent_old_pr[ret_slot[k]] : '0;
        rt_pc[k]       <= ret_lane[k] ? ent_pc[ret_slot[k]]     : '0;
      end

      if (disp_ok) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (disp_valid[k]) begin
            ent_valid[disp_slot[k]] <= 1'b1;
            ent_done[disp_slot[k]]  <= 1'b0;
          end
        end
      end

      rt_valid <= ret_lane;
      rt_count <= ret_n[1:0];
      head     <= head + idx_t'(ret_n);
      tail     <= tail + (disp_ok ? idx_t'(disp_n) : idx_t'(0));
      occ      <= occ + (disp_ok ? disp_n : cnt_t'(0)) - ret_n;
    end
  end

endmodule

// File: tb/tb_rob_retire_stage.sv
// Directed and random stimulus for rob_retire_stage, checked against a queue-based ROB model.
module tb_rob_retire_stage;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int W  = 3;
  localparam int PW = 6;
  localparam int XL = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   squash;
  logic [W-1:0]           disp_valid;
  logic [W-1:0][4:0]      disp_arch_reg;
  logic [W-1:0][PW-1:0]   disp_new_pr;
  logic [W-1:0][PW-1:0]   disp_old_pr;
  logic [W-1:0][XL-1:0]   disp_pc;
  logic [W-1:0]           cs_retire_valid;
  logic [W-1:0][AW-1:0]   cs_retire_idx;
  logic [AW-1:0]          rob_tail_idx;
  logic [AW:0]            rob_free_slots;
  logic                   disp_reject;
  logic [W-1:0]           rt_valid;
  logic [W-1:0][4:0]      rt_arch_reg;
  logic [W-1:0][PW-1:0]   rt_new_pr;
  logic [W-1:0][PW-1:0]   rt_old_pr;
  logic [W-1:0][XL-1:0]   rt_pc;
  logic [1:0]             rt_count;

  always #5 clk = ~clk;

  rob_retire_stage #(.ROB_DEPTH(D), .ROB_ADDR_WIDTH(AW), .WIDTH(W),
                     .PR_ADDR_WIDTH(PW), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .squash(squash),
    .disp_valid(disp_valid), .disp_arch_reg(disp_arch_reg),
    .disp_new_pr(disp_new_pr), .disp_old_pr(disp_old_pr), .disp_pc(disp_pc),
    .cs_retire_valid(cs_retire_valid), .cs_retire_idx(cs_retire_idx),
    .rob_tail_idx(rob_tail_idx), .rob_free_slots(rob_free_slots),
    .disp_reject(disp_reject), .rt_valid(rt_valid), .rt_arch_reg(rt_arch_reg),
    .rt_new_pr(rt_new_pr), .rt_old_pr(rt_old_pr), .rt_pc(rt_pc), .rt_count(rt_count)
  );

  typedef struct {
    int            idx;
    logic [4:0]    arch;
    logic [PW-1:0] npr;
    logic [PW-1:0] opr;
    logic [XL-1:0] pc;
    bit            done;
  } ent_t;

  ent_t         q[$];
  int           m_tail;
  logic [W-1:0] e_valid;
  int           e_count;
  ent_t         e_rt[W];
  bit           e_rej;
  int           n_chk  = 0;
  int           n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail  = 0;
    e_valid = '0;
    e_count = 0;
    e_rej   = 0;
  endtask

  task automatic idle();
    squash          = 1'b0;
    disp_valid      = '0;
    cs_retire_valid = '0;
  endtask

  task automatic set_disp(input int n);
    for (int k = 0; k < W; k++) begin
      disp_valid[k]    = (k < n);
      disp_arch_reg[k] = 5'($urandom);
      disp_new_pr[k]   = PW'($urandom);
      disp_old_pr[k]   = PW'($urandom);
      disp_pc[k]       = $urandom & 32'hffff_fffc;
    end
  endtask

  task automatic set_comp(input int lane, input int idx);
    cs_retire_valid[lane] = 1'b1;
    cs_retire_idx[lane]   = AW'(idx);
  endtask

  task automatic check_outputs();
    chk("rt_valid", rt_valid, e_valid);
    chk("rt_count", rt_count, e_count);
    for (int k = 0; k < e_count; k++) begin
      chk("rt_arch_reg", rt_arch_reg[k], e_rt[k].arch);
      chk("rt_new_pr", rt_new_pr[k], e_rt[k].npr);
      chk("rt_old_pr", rt_old_pr[k], e_rt[k].opr);
      chk("rt_pc", rt_pc[k], e_rt[k].pc);
    end
    chk("free_slots", rob_free_slots, D - q.size());
    chk("tail_idx", rob_tail_idx, m_tail);
    chk("disp_reject", disp_reject, e_rej);
  endtask

  // Advance one clock: predict from the pre-edge model state, then compare.
  task automatic cycle();
    int   pre, n, r, off;
    ent_t e;
    e_valid = '0;
    e_count = 0;
    e_rej   = 0;
    if (squash) begin
      q.delete();
      m_tail = 0;
    end else begin
      pre = q.size();
      r   = 0;
      while (r < W && r < q.size() && q[r].done) r++;
      for (int k = 0; k < r; k++) begin
        e_rt[k]    = q[k];
        e_valid[k] = 1'b1;
      end
      e_count = r;
      for (int k = 0; k < W; k++)
        if (cs_retire_valid[k])
          foreach (q[i]) if (q[i].idx == int'(cs_retire_idx[k])) q[i].done = 1;
      repeat (r) void'(q.pop_front());
      n = $countones(disp_valid);
      if (n <= D - pre) begin
        off = 0;
        for (int k = 0; k < W; k++) begin
          if (disp_valid[k]) begin
            e.idx  = (m_tail + off) % D;
            e.arch = disp_arch_reg[k];
            e.npr  = disp_new_pr[k];
            e.opr  = disp_old_pr[k];
            e.pc   = disp_pc[k];
            e.done = 0;
            q.push_back(e);
            off++;
          end
        end
        m_tail = (m_tail + n) % D;
      end else begin
        e_rej = 1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_free"}, rob_free_slots, D);
    chk({tag, "_tail"}, rob_tail_idx, 0);
    chk({tag, "_rej"}, disp_reject, 0);
    chk({tag, "_rtv"}, rt_valid, 0);
    chk({tag, "_rtc"}, rt_count, 0);
    chk({tag, "_rtpc"}, rt_pc, 0);
    chk({tag, "_rtpr"}, {rt_new_pr, rt_old_pr, rt_arch_reg}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    set_disp(0);
    cs_retire_idx = '0;
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (5) cycle();

    // Single entry: dispatch, complete, retire.
    set_disp(1);
    disp_arch_reg[0] = 5'd3;
    disp_new_pr[0]   = 6'h01;
    disp_old_pr[0]   = 6'h21;
    disp_pc[0]       = 32'h100;
    cycle();
    idle(); set_comp(0, 0); cycle();
    idle(); cycle();
    chk("t1_rtv", rt_valid, 3'b001);
    chk("t1_newpr", rt_new_pr[0], 6'h01);
    chk("t1_oldpr", rt_old_pr[0], 6'h21);
    chk("t1_pc", rt_pc[0], 32'h100);
    chk("t1_free", rob_free_slots, 32);

    // Out-of-order completion holds retire until the head completes.
    idle(); squash = 1'b1; cycle();
    idle(); set_disp(3); cycle();
    idle(); set_comp(0, 2); cycle();
    idle(); set_comp(1, 1); cycle();
    chk("t3_hold", rt_valid, 3'b000);
    idle(); set_comp(2, 0); cycle();
    idle(); cycle();
    chk("t3_rtv", rt_valid, 3'b111);
    chk("t3_cnt", rt_count, 3);

    // Fill to capacity, reject overflow, then retire three.
    idle(); squash = 1'b1; cycle();
    for (int i = 0; i < 10; i++) begin idle(); set_disp(3); cycle(); end
    idle(); set_disp(2); cycle();
    chk("fill_free", rob_free_slots, 0);
    idle(); set_disp(1); cycle();
    chk("fill_rej", disp_reject, 1);
    chk("fill_tail", rob_tail_idx, 0);
    idle(); set_comp(0, 0); set_comp(1, 1); set_comp(2, 2); cycle();
    chk("fill_rej_clr", disp_reject, 0);
    idle(); cycle();
    chk("fill_ret", rt_count, 3);
    chk("fill_free3", rob_free_slots, 3);

    // Move head to 30, then retire a group that wraps past index 31.
    idle(); squash = 1'b1; cycle();
    for (int i = 0; i < 10; i++) begin idle(); set_disp(3); cycle(); end
    for (int i = 0; i < 10; i++) begin
      idle(); set_comp(0, 3*i); set_comp(1, 3*i+1); set_comp(2, 3*i+2); cycle();
    end
    idle(); cycle();
    idle(); cycle();
    chk("wrap_empty", rob_free_slots, 32);
    chk("wrap_tail30", rob_tail_idx, 30);
    idle(); set_disp(3); cycle();
    idle(); set_comp(0, 30); set_comp(1, 31); set_comp(2, 0); cycle();
    idle(); cycle();
    chk("wrap_cnt", rt_count, 3);
    idle(); set_disp(1); cycle();
    idle(); set_comp(0, 1); cycle();
    idle(); cycle();
    chk("wrap_head1", rt_valid, 3'b001);
    chk("wrap_tail2", rob_tail_idx, 2);

    // Squash with ten live entries and a same-cycle completion.
    idle(); squash = 1'b1; cycle();
    for (int i = 0; i < 3; i++) begin idle(); set_disp(3); cycle(); end
    idle(); set_disp(1); cycle();
    idle(); set_comp(0, 0); set_comp(1, 1); cycle();
    idle(); squash = 1'b1; set_comp(0, 5); set_disp(2); cycle();
    chk("sq_rtv", rt_valid, 3'b000);
    chk("sq_free", rob_free_slots, 32);
    chk("sq_tail", rob_tail_idx, 0);

    // Same sequence, interrupted by an asynchronous reset pulse between edges.
    for (int i = 0; i < 3; i++) begin idle(); set_disp(3); cycle(); end
    idle(); set_disp(1); cycle();
    idle(); set_comp(0, 0); set_comp(1, 1); cycle();
    idle(); cycle();
    chk("ar_pre_rtv", rt_valid, 3'b011);
    #2 rst = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    #1 rst = 1'b1;
    repeat (2) begin idle(); cycle(); end

    // Random traffic, including duplicate and stale completion indices.
    for (int c = 0; c < 400; c++) begin
      idle();
      squash = ($urandom_range(0, 59) == 0);
      set_disp($urandom_range(0, 3));
      for (int k = 0; k < W; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (q.size() > 0 && $urandom_range(0, 7) != 0)
            set_comp(k, q[$urandom_range(0, q.size() - 1)].idx);
          else
            set_comp(k, $urandom_range(0, D - 1));
        end
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
